// File: rtl/sequential_mult.sv
// sequential_mult
// ---------------------------------------------------------------------------
// Iterative unsigned radix-2 shift-and-add multiplier. One multiplier bit is
// consumed per clock; a 2*SIZE-bit product is produced SIZE cycles after the
// start edge.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous, active-high reset
//   start  - operation request, sampled only while idle
//   A      - SIZE-bit unsigned multiplicand, sampled with start
//   B      - SIZE-bit unsigned multiplier, sampled with start
//   P      - 2*SIZE-bit product register, holds the last completed result
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse, P has just been updated
// ---------------------------------------------------------------------------
module sequential_mult #(
  parameter int SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   A,
  input  logic [SIZE-1:0]   B,
  output logic [2*SIZE-1:0] P,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     mcnd_q, mcnd_d;
  logic [SIZE:0]       hi_q, hi_d;
  logic [SIZE-1:0]     lo_q, lo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*SIZE-1:0]   p_q, p_d;
  logic                done_q, done_d;

  logic [SIZE-1:0]     addend;
  logic [SIZE:0]       sum;

  // hi_q[SIZE] is always 0 after a shift, so adding the full register equals
  // adding its lower SIZE bits; the carry lands in sum[SIZE].
  always_comb begin
    addend = lo_q[0] ? mcnd_q : '0;
    sum    = hi_q + {1'b0, addend};
  end

  always_comb begin
    state_d = state_q;
    mcnd_d  = mcnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcnd_d  = A;
          hi_d    = '0;
          lo_d    = B;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift the partial product right; the consumed multiplier bit falls
        // off the bottom of lo while the new product bit enters at its top.
        hi_d  = {1'b0, sum[SIZE:1]};
        lo_d  = {sum[0], lo_q[SIZE-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          p_d     = {sum, lo_q[SIZE-1:1]};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcnd_q  <= mcnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_sequential_mult.sv
// tb_sequential_mult
// ---------------------------------------------------------------------------
// Bench for sequential_mult. Two instances share clock and reset: a SIZE=32
// one for the directed scenarios and a SIZE=8 one for the 8-bit corner and a
// random sweep. The reference is plain a*b; a product is expected exactly
// SIZE edges after the start edge, with P holding its previous value before.
// ---------------------------------------------------------------------------
module tb_sequential_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        busy32, done32;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        busy8, done8;

  int compared   = 0;
  int mismatched = 0;

  // Model state: last product each instance should be holding.
  logic [63:0] last_p32, last_p8;

  always #5 clk = ~clk;

  sequential_mult #(.SIZE(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
    .P(p32), .busy(busy32), .done(done32)
  );

  sequential_mult #(.SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .P(p8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_p(input bit w8);
    return w8 ? {48'b0, p8} : p32;
  endfunction

  function automatic logic [63:0] get_busy(input bit w8);
    return {63'b0, w8 ? busy8 : busy32};
  endfunction

  function automatic logic [63:0] get_done(input bit w8);
    return {63'b0, w8 ? done8 : done32};
  endfunction

  task automatic set_in(input bit w8, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; a32 = a; b32 = b;
    end
  endtask

  // Called at posedge+1; start is sampled at the next edge (edge 0).
  task automatic start_op(input bit w8, input logic [31:0] a, input logic [31:0] b);
    set_in(w8, 1'b1, a, b);
    @(posedge clk); #1;
    // Operands may change freely after the start edge.
    set_in(w8, 1'b0, $urandom, $urandom);
    chk("busy_after_start", get_busy(w8), 64'd1);
    chk("done_after_start", get_done(w8), 64'd0);
  endtask

  // Walks edges 1..SIZE. inject>0 drives a competing start after that edge.
  task automatic finish_op(input bit w8, input logic [63:0] exp, input int inject);
    int n;
    logic [63:0] prev;
    n    = w8 ? 8 : 32;
    prev = w8 ? last_p8 : last_p32;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k < n) begin
        chk("busy_running", get_busy(w8), 64'd1);
        chk("done_early", get_done(w8), 64'd0);
        chk("p_held_running", get_p(w8), prev);
      end else begin
        chk("done_pulse", get_done(w8), 64'd1);
        chk("busy_at_done", get_busy(w8), 64'd0);
        chk("product", get_p(w8), exp);
        if (w8) last_p8 = exp; else last_p32 = exp;
      end
      if (inject != 0 && k == inject) set_in(w8, 1'b1, 32'd2, 32'd2);
      else if (inject != 0 && k == inject + 1) set_in(w8, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic idle(input bit w8, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk("idle_done", get_done(w8), 64'd0);
      chk("idle_busy", get_busy(w8), 64'd0);
      chk("idle_p", get_p(w8), w8 ? last_p8 : last_p32);
    end
  endtask

  task automatic op(input bit w8, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp = w8 ? 64'(a[7:0]) * 64'(b[7:0]) : 64'(a) * 64'(b);
    start_op(w8, a, b);
    finish_op(w8, exp, 0);
    $display("op w8=%0d a=0x%0h b=0x%0h p=0x%0h exp=0x%0h", w8, a, b, get_p(w8), exp);
  endtask

  initial begin
    rst = 1'b1;
    start32 = 1'b0; start8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    last_p32 = '0; last_p8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_p32", p32, 64'd0);
    chk("reset_busy32", {63'b0, busy32}, 64'd0);
    chk("reset_done32", {63'b0, done32}, 64'd0);
    chk("reset_p8", {48'b0, p8}, 64'd0);
    chk("reset_busy8", {63'b0, busy8}, 64'd0);
    rst = 1'b0;
    idle(1'b0, 2);

    // Basic product and full-width corner
    op(1'b0, 32'd3, 32'd5);
    idle(1'b0, 2);
    op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("max_product", p32, 64'hFFFF_FFFE_0000_0001);
    idle(1'b0, 1);
    op(1'b0, 32'd0, 32'h1234_5678);
    idle(1'b0, 1);

    // start while busy must be ignored
    start_op(1'b0, 32'd7, 32'd9);
    finish_op(1'b0, 64'd63, 10);
    $display("ignore-start p=%0d", p32);
    idle(1'b0, 40);

    // Back-to-back: second start driven during the done cycle
    op(1'b0, 32'd5, 32'd6);
    op(1'b0, 32'h1_0000, 32'h1_0000);
    chk("b2b_product", p32, 64'h1_0000_0000);
    idle(1'b0, 1);

    // Reset in the middle of an operation
    start_op(1'b0, 32'd100, 32'd100);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_p", p32, 64'd0);
    chk("midrst_busy", {63'b0, busy32}, 64'd0);
    chk("midrst_done", {63'b0, done32}, 64'd0);
    last_p32 = '0;
    last_p8  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset mid-op p=0x%0h busy=%0d done=%0d", p32, busy32, done32);
    idle(1'b0, 40);
    op(1'b0, 32'd100, 32'd100);
    chk("after_rst_product", p32, 64'd10000);
    idle(1'b0, 1);

    // SIZE=8 instance
    op(1'b1, 32'hFF, 32'hFF);
    chk("p8_max", {48'b0, p8}, 64'hFE01);
    idle(1'b1, 1);
    for (int i = 0; i < 200; i++) begin
      op(1'b1, $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle(1'b1, 1);
    end
    idle(1'b1, 2);

    // Random 32-bit operands, sometimes chained back-to-back
    for (int i = 0; i < 20; i++) begin
      op(1'b0, $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle(1'b0, 1);
    end
    idle(1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
